// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity selectors and the
// oversampling baud divisor used by both the RX and TX blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Clocks per oversampling tick, truncated.
    function automatic int uart_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick divider: one-cycle tick every DIV clocks, restarted by a
// synchronous clear so the tick phase can be aligned to an external event.
module uart_baud_tick #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with mid-bit 3-sample majority vote.
// Define UART_RX_PARITY_EN to expect and check one parity bit per frame.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int OW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int SW  = $clog2(STOP_BITS + 1);

    localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] SMP_A     = OW'(M - 1);
    localparam logic [OW-1:0] SMP_B     = OW'(M);
    localparam logic [OW-1:0] SMP_C     = OW'(M + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_rx_os: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_os: OVERSAMPLE must be even and at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2
        || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_frame
        $error("uart_rx_os: illegal frame format parameters");
    end

    // valid is a one-cycle strobe with no back-pressure; frame_err and
    // parity_err are meaningful only while valid is high, data_out holds after.
    rx_state_t      state, state_n;
    logic           rx_meta, rx_s, rx_prev;
    logic           tick, bit_end;
    logic [OW-1:0]  os_cnt;
    logic           s_a, s_b, vote, vote_stb;
    logic [DATA_BITS-1:0] shift_q;
    logic [BW-1:0]  bit_cnt;
    logic [SW-1:0]  stop_cnt;
    logic           ferr_acc, frame_bad;
    logic           start_det, shift_en, stop_en, done;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SEL = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
    logic           par_en, par_bit, par_bad;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (start_det),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            os_cnt <= '0;
        end else if (start_det) begin
            os_cnt <= '0;
        end else if (tick) begin
            os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
        end
    end

    assign bit_end = tick && (os_cnt == OS_LAST);

    // Third sample is taken live at M+1 and voted with the two held ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_a      <= 1'b1;
            s_b      <= 1'b1;
            vote     <= 1'b1;
            vote_stb <= 1'b0;
        end else begin
            vote_stb <= tick && (os_cnt == SMP_C);
            if (tick && os_cnt == SMP_A) s_a <= rx_s;
            if (tick && os_cnt == SMP_B) s_b <= rx_s;
            if (tick && os_cnt == SMP_C) vote <= (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
        end
    end

    assign frame_bad = ferr_acc | ~vote;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start_det = 1'b0;
        shift_en  = 1'b0;
        stop_en   = 1'b0;
        done      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    start_det = 1'b1;
                    state_n   = START;
                end
            end
            START: begin
                if (vote_stb && vote) state_n = IDLE;
                else if (bit_end)     state_n = DATA;
            end
            DATA: begin
                shift_en = vote_stb;
                if (bit_end && bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                par_en = vote_stb;
`endif
                if (bit_end) state_n = STOP;
            end
            STOP: begin
                // Leave right after the last vote so a back-to-back start edge is seen.
                if (vote_stb) begin
                    stop_en = 1'b1;
                    if (stop_cnt == STOP_LAST) begin
                        done    = 1'b1;
                        state_n = frame_bad ? WAIT_IDLE : IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= '0;
            ferr_acc <= 1'b0;
        end else if (start_det) begin
            bit_cnt  <= '0;
            stop_cnt <= '0;
            ferr_acc <= 1'b0;
        end else begin
            if (shift_en) begin
                shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (stop_en) begin
                stop_cnt <= stop_cnt + 1'b1;
                if (!vote) ferr_acc <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= done;
            frame_err <= done & frame_bad;
            if (done) data_out <= shift_q;
        end
    end

`ifdef UART_RX_PARITY_EN
    assign par_bad = ((^shift_q) ^ par_bit) != PAR_SEL;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_en) par_bit <= vote;
            parity_err <= done & par_bad;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised oversampling UART receiver and the next-generation serial-input block of the UART subsystem. It synchronises the asynchronous `rx` line, detects and validates the start bit, and samples each bit at mid-bit with a 3-sample majority vote. It assembles a frame of configurable width and stop-bit count, then presents the data word with a one-cycle `valid` strobe plus framing and parity status to the downstream FIFO or register interface.

## Interface
- `CLK_FREQ`, 50000000: system clock frequency in Hz.
- `BAUD`, 115200: line bit rate in baud.
- `OVERSAMPLE`, 16: ticks per bit; even, ≥ 8.
- `DATA_BITS`, 8: payload width; legal range 5..9.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity; only meaningful with `UART_RX_PARITY_EN`.
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `rx`  in  1: asynchronous serial input; idle level is high.
- `data_out`  out  DATA_BITS: last received word, LSB first on the line; holds until the next `valid`.
- `valid`  out  1: one-cycle strobe for a completed frame.
- `frame_err`  out  1: stop bit sampled low; qualified by `valid`.
- `parity_err`  out  1: parity mismatch; qualified by `valid`; tied 0 without `UART_RX_PARITY_EN`.
- `busy`  out  1: high from start detection until the frame ends or is aborted.

## Operation
- `rx` passes through a 2-FF synchroniser to produce `rx_s`. All logic uses `rx_s`.
- Tick generator: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), truncated. Elaboration fails unless DIV ≥ 2. It produces a 1-cycle `tick` every DIV cycles and is cleared to 0 on start detection, which phase-aligns sampling to the start edge.
- Bit sample: a tick counter counts 0..OVERSAMPLE-1 within each bit. Samples are taken at counts M-1, M and M+1, where M = OVERSAMPLE/2. The bit value is the majority of the three samples, registered at count M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE → START on a falling edge of `rx_s` (previous 1, current 0). A line held low does not start a frame.
- START: if the voted value is 1, treat it as a glitch and return to IDLE with no output. If it is 0, go to DATA at the end of the bit.
- DATA: shift the voted bits in LSB first. After DATA_BITS bits, go to PARITY if `UART_RX_PARITY_EN` is defined, otherwise go to STOP.
- PARITY: the error is (XOR of data ^ received bit) ≠ PARITY_ODD.
- STOP: vote on each stop bit. If any stop bit is 0, set `frame_err`. After the vote on the last stop bit, do not wait for the end of that bit:
  - with no frame error, go directly to IDLE, so the next start edge is accepted immediately;
  - with a frame error, go to WAIT_IDLE.
- WAIT_IDLE → IDLE once `rx_s` = 1. This prevents a break condition from generating spurious frames.
- Output update: `data_out`, `frame_err` and `parity_err` are updated in the same cycle that `valid` = 1. Error flags stay 0 while `valid` = 0.
- `busy` = 1 in START, DATA, PARITY, STOP and WAIT_IDLE.

## Timing
- Reset values: `data_out` = 0, `valid` = 0, `frame_err` = 0, `parity_err` = 0, `busy` = 0. FSM = IDLE, synchroniser flops = 1.
- Start edge on `rx` to `busy` high: 3 clk (2 synchroniser + 1 edge-detect register).
- `valid` rises 1 clk after the majority register for the last stop bit. Start edge to `valid` ≈ 3 + ((1+DATA_BITS+P+STOP_BITS-1)*OVERSAMPLE + M+1)*DIV clk, where P = 1 if parity is enabled.
- Reset mid-frame aborts immediately; the next frame is received normally.
- Back-to-back frames with no idle gap are received without loss.
- All counter widths use $clog2 and wrap only by explicit compare; there is no implicit overflow.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state, parity check and `parity_err` are compiled in; each frame carries one parity bit.
- Not defined: no parity bit is expected, and `parity_err` is a constant 0.

## Structure
- Package `uart_pkg` holds:
  - the `rx_state_t` enum;
  - the parity constants `PAR_EVEN` = 0 and `PAR_ODD` = 1;
  - a `uart_div` function computing DIV, shared with the TX block.
- Sub-module `uart_baud_tick`: a divider with synchronous clear and a `tick` output. It is shared with the future oversampling TX.

## Test plan
Bench parameters: CLK_FREQ = 32000000, BAUD = 1000000, OVERSAMPLE = 16, which gives DIV = 2 and 32 clk per bit.
- Send 0xA5 as 8N1 → one `valid` pulse, `data_out` = 0xA5, `frame_err` = 0, `parity_err` = 0, `busy` low after the stop bit.
- Pulse `rx` low for 8 clk on an idle line → no `valid`, `busy` returns to 0 within 1 bit time.
- Send 0x3C with a stop bit of 0, then hold `rx` low for 200 clk → `valid` with `frame_err` = 1 and `data_out` = 0x3C. No further `valid` occurs until `rx` returns high and a new start bit arrives.
- With `UART_RX_PARITY_EN` defined, PARITY_ODD = 0, send 0x07 with parity bit 0 → `parity_err` = 1. Repeat with parity bit 1 → `parity_err` = 0.
- Assert `reset` during data bit 4 of a frame → all outputs read 0 and `busy` = 0. The next frame, 0x5A, is received correctly.
- Send frames 0x00 then 0xFF back-to-back with no idle gap → two `valid` pulses about 320 clk apart, with the correct data and no errors.
